// File: rtl/lsu_mem_initiator_pkg.sv
// Shared definitions for the LSU memory initiator: DM_* access codes (values
// mirror ctrl_encode_def), FSM state encodings and access-size helpers.
package lsu_mem_initiator_pkg;

    localparam logic [2:0] DM_WORD              = 3'b000;
    localparam logic [2:0] DM_HALFWORD          = 3'b001;
    localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'b010;
    localparam logic [2:0] DM_BYTE              = 3'b011;
    localparam logic [2:0] DM_BYTE_UNSIGNED     = 3'b100;

    typedef enum logic [2:0] {
        LSU_IDLE = 3'd0,
        LSU_RD0  = 3'd1,
        LSU_RD1  = 3'd2,
        LSU_WR0  = 3'd3,
        LSU_WR1  = 3'd4,
        LSU_RESP = 3'd5
    } lsu_state_e;

    typedef struct packed {
        logic        we;
        logic [2:0]  typ;
        logic [1:0]  off;
        logic [31:0] wdata;
    } lsu_req_t;

    // Unknown codes are treated as full words.
    function automatic logic [2:0] dm_bytes(input logic [2:0] t);
        case (t)
            DM_BYTE, DM_BYTE_UNSIGNED:         return 3'd1;
            DM_HALFWORD, DM_HALFWORD_UNSIGNED: return 3'd2;
            default:                           return 3'd4;
        endcase
    endfunction

    function automatic logic dm_crosses(input logic [2:0] t, input logic [1:0] off);
        return ({1'b0, off} + dm_bytes(t)) > 3'd4;
    endfunction

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// Request/response handshake plus word-memory bus of the LSU initiator.
// slave = the initiator itself, master = pipeline and memory side.
interface lsu_mem_initiator_if;
    import lsu_mem_initiator_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [2:0]  mem_type;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_type, req_addr, req_wdata, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_type, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_type, req_addr, req_wdata, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_type, mem_addr, mem_wdata
    );

endinterface

// File: rtl/lsu_mem_initiator_align_ext.sv
// Combinational data path over the two-word window {w1,w0}: load shift/extend
// and store byte-lane merge, both keyed by access size and byte offset.
module lsu_align_ext
    import lsu_mem_initiator_pkg::*;
(
    input  logic [2:0]  typ,
    input  logic [1:0]  off,
    input  logic [31:0] w0,
    input  logic [31:0] w1,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] merged_lo,
    output logic [31:0] merged_hi
);

    logic [63:0] win, lane_data, lane_mask, merged;
    logic [31:0] shifted;
    logic [7:0]  be_base, byte_en;
    logic [5:0]  sh;

    assign sh      = {off, 3'b000};
    assign win     = {w1, w0};
    assign shifted = win[sh +: 32];

    always_comb begin
        rdata = shifted;
        case (typ)
            DM_BYTE:              rdata = {{24{shifted[7]}}, shifted[7:0]};
            DM_BYTE_UNSIGNED:     rdata = {24'h0, shifted[7:0]};
            DM_HALFWORD:          rdata = {{16{shifted[15]}}, shifted[15:0]};
            DM_HALFWORD_UNSIGNED: rdata = {16'h0, shifted[15:0]};
            default:              ;
        endcase
    end

    // Store width only matters here, so unsigned codes behave as their signed twins.
    always_comb begin
        case (dm_bytes(typ))
            3'd1:    be_base = 8'h01;
            3'd2:    be_base = 8'h03;
            default: be_base = 8'h0F;
        endcase
    end

    assign byte_en   = be_base << off;
    assign lane_data = {32'h0, wdata} << sh;

    for (genvar i = 0; i < 8; i++) begin : g_lane
        assign lane_mask[8*i +: 8] = {8{byte_en[i]}};
    end

    assign merged    = (win & ~lane_mask) | (lane_data & lane_mask);
    assign merged_lo = merged[31:0];
    assign merged_hi = merged[63:32];

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: turns byte/half/word accesses into whole-word memory
// reads and read-modify-writes, splitting word-crossing accesses in two.
module lsu_mem_initiator
    import lsu_mem_initiator_pkg::*;
#(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic clk,
    input  logic rst,
    lsu_mem_initiator_if.slave bus
);

    lsu_state_e  state;
    lsu_req_t    req_q;
    logic        cross_q, cross_in;
    logic [31:0] w0_q, w1_q, w0_src, w1_src;
    logic [31:0] ld_data, mrg_lo, mrg_hi;
    logic        resp_valid_q, resp_err_q, mem_we_q;
    logic [31:0] resp_rdata_q, mem_addr_q, mem_wdata_q;

    assign cross_in = dm_crosses(bus.req_type, bus.req_addr[1:0]);

    // The word being read this cycle feeds the data path directly, so results
    // can be registered on the same edge that captures it.
    assign w0_src = (state == LSU_RD0) ? bus.mem_rdata : w0_q;
    assign w1_src = (state == LSU_RD1) ? bus.mem_rdata : (cross_q ? w1_q : 32'h0);

    lsu_align_ext u_align (
        .typ      (req_q.typ),
        .off      (req_q.off),
        .w0       (w0_src),
        .w1       (w1_src),
        .wdata    (req_q.wdata),
        .rdata    (ld_data),
        .merged_lo(mrg_lo),
        .merged_hi(mrg_hi)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= LSU_IDLE;
            req_q        <= '0;
            cross_q      <= 1'b0;
            w0_q         <= '0;
            w1_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            case (state)
                LSU_IDLE: if (bus.req_valid) begin
                    req_q   <= '{we: bus.req_we, typ: bus.req_type,
                                 off: bus.req_addr[1:0], wdata: bus.req_wdata};
                    cross_q <= cross_in;
                    if (cross_in && !SPLIT_MISALIGNED) begin
                        state        <= LSU_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= '0;
                    end else begin
                        state      <= LSU_RD0;
                        mem_addr_q <= {bus.req_addr[31:2], 2'b00};
                    end
                end
                LSU_RD0: begin
                    w0_q <= bus.mem_rdata;
                    if (cross_q) begin
                        state      <= LSU_RD1;
                        mem_addr_q <= mem_addr_q + 32'd4;
                    end else if (req_q.we) begin
                        state       <= LSU_WR0;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= mrg_lo;
                    end else begin
                        state        <= LSU_RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= ld_data;
                    end
                end
                LSU_RD1: begin
                    w1_q <= bus.mem_rdata;
                    if (req_q.we) begin
                        state       <= LSU_WR0;
                        mem_addr_q  <= mem_addr_q - 32'd4;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= mrg_lo;
                    end else begin
                        state        <= LSU_RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= ld_data;
                    end
                end
                LSU_WR0: begin
                    if (cross_q) begin
                        state       <= LSU_WR1;
                        mem_addr_q  <= mem_addr_q + 32'd4;
                        mem_wdata_q <= mrg_hi;
                    end else begin
                        state        <= LSU_RESP;
                        mem_we_q     <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= '0;
                    end
                end
                LSU_WR1: begin
                    state        <= LSU_RESP;
                    mem_we_q     <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= '0;
                end
                LSU_RESP: if (bus.resp_ready) begin
                    state        <= LSU_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == LSU_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_type   = DM_WORD;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Randomised bench for lsu_mem_initiator against a byte-addressed memory model,
// plus directed cases for extension, splitting, backpressure, reject and reset.
module tb_lsu_mem_initiator;
    import lsu_mem_initiator_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_mem_initiator_if b ();
    lsu_mem_initiator_if b2 ();

    lsu_mem_initiator #(.SPLIT_MISALIGNED(1'b1)) dut    (.clk(clk), .rst(rst), .bus(b.slave));
    lsu_mem_initiator #(.SPLIT_MISALIGNED(1'b0)) dut_ns (.clk(clk), .rst(rst), .bus(b2.slave));

    int n_chk = 0;
    int n_fail = 0;

    // Word memories seen by the DUTs; only in-range words exist.
    logic [31:0] mem  [16];
    logic [31:0] mem2 [16];
    logic        pk_en  = 1'b0;
    logic [3:0]  pk_idx = '0;
    logic [31:0] pk_val = '0;

    assign b.mem_rdata  = (b.mem_addr  < 32'd64) ? mem[b.mem_addr[5:2]]   : 32'h0;
    assign b2.mem_rdata = (b2.mem_addr < 32'd64) ? mem2[b2.mem_addr[5:2]] : 32'h0;

    always @(posedge clk) begin
        if (pk_en) mem[pk_idx] <= pk_val;
        else if (b.mem_we && b.mem_addr < 32'd64) mem[b.mem_addr[5:2]] <= b.mem_wdata;
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem2[i] <= 32'h80F0_0000 | 32'(i);
        end else if (b2.mem_we && b2.mem_addr < 32'd64) mem2[b2.mem_addr[5:2]] <= b2.mem_wdata;
    end

    // Reference: plain byte array, little-endian.
    logic [7:0] rmem [64];

    logic [31:0] exp_rdata = '0;
    logic        exp_err   = 1'b0;
    logic [31:0] last_rdata = '0;
    int          ns_we = 0;
    typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
    wr_t wq[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] t);
        if (t == DM_BYTE || t == DM_BYTE_UNSIGNED) return 1;
        if (t == DM_HALFWORD || t == DM_HALFWORD_UNSIGNED) return 2;
        return 4;
    endfunction

    function automatic logic [7:0] rbyte(input logic [31:0] a);
        return (a < 32'd64) ? rmem[a[5:0]] : 8'h00;
    endfunction

    task automatic model_apply(input logic we, input logic [2:0] ty, input logic [31:0] a,
                               input logic [31:0] wd, output logic [31:0] rd);
        int n;
        logic [31:0] v, ba;
        n = nbytes(ty);
        v = '0;
        for (int i = 0; i < n; i++) begin
            ba = a + 32'(i);
            if (we) begin
                if (ba < 32'd64) rmem[ba[5:0]] = wd[8*i +: 8];
            end else v[8*i +: 8] = rbyte(ba);
        end
        rd = '0;
        if (!we) begin
            case (ty)
                DM_BYTE:              rd = {{24{v[7]}}, v[7:0]};
                DM_BYTE_UNSIGNED:     rd = {24'h0, v[7:0]};
                DM_HALFWORD:          rd = {{16{v[15]}}, v[15:0]};
                DM_HALFWORD_UNSIGNED: rd = {16'h0, v[15:0]};
                default:              rd = v;
            endcase
        end
    endtask

    // Single compare process for the split-capable DUT; also tallies the other's writes.
    always @(negedge clk) begin
        if (!rst) begin
            check("mem_type", 32'(b.mem_type), 32'(DM_WORD));
            if (b.mem_we) wq.push_back('{b.mem_addr, b.mem_wdata});
            if (b.resp_valid) begin
                check("resp_rdata", b.resp_rdata, exp_rdata);
                check("resp_err", 32'(b.resp_err), 32'(exp_err));
                check("req_ready_busy", 32'(b.req_ready), 32'h0);
                last_rdata = b.resp_rdata;
            end
            if (b2.mem_we) ns_we++;
        end
    end

    task automatic poke(input int w, input logic [31:0] v);
        pk_en = 1'b1; pk_idx = 4'(w); pk_val = v;
        @(posedge clk); #1;
        pk_en = 1'b0;
        for (int i = 0; i < 4; i++) rmem[4*w+i] = v[8*i +: 8];
    endtask

    task automatic run(input logic we, input logic [2:0] ty, input logic [31:0] a,
                       input logic [31:0] wd, input int hold, output int lat);
        int words, rv;
        logic [31:0] wa;
        words = ((int'(a[1:0]) + nbytes(ty)) > 4) ? 2 : 1;
        wa = {a[31:2], 2'b00};
        model_apply(we, ty, a, wd, exp_rdata);
        exp_err = 1'b0;
        wq.delete();
        b.req_valid = 1'b1; b.req_we = we; b.req_type = ty; b.req_addr = a; b.req_wdata = wd;
        b.resp_ready = (hold == 0);
        @(posedge clk); #1;
        b.req_valid = 1'b0;
        lat = 0; rv = 0;
        while (1) begin
            @(posedge clk); #1;
            lat++;
            if (b.req_ready || lat > 60) break;
            if (b.resp_valid) begin
                rv++;
                if (rv > hold) b.resp_ready = 1'b1;
            end
        end
        check("latency", 32'(lat), 32'(hold + (we ? 1 + 2*words : 1 + words)));
        check("write_count", 32'(wq.size()), 32'(we ? words : 0));
        if (we && wq.size() == words) begin
            check("write_addr0", wq[0].a, wa);
            if (words == 2) check("write_addr1", wq[1].a, wa + 32'd4);
        end
        for (int w = 0; w < 16; w++)
            check("mem_image", mem[w], {rmem[4*w+3], rmem[4*w+2], rmem[4*w+1], rmem[4*w]});
    endtask

    task automatic run_ns(input string nm, input logic we, input logic [2:0] ty,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] erd, input logic eerr);
        int t, we0;
        we0 = ns_we;
        b2.req_valid = 1'b1; b2.req_we = we; b2.req_type = ty; b2.req_addr = a; b2.req_wdata = wd;
        b2.resp_ready = 1'b1;
        @(posedge clk); #1;
        b2.req_valid = 1'b0;
        t = 0;
        while (!b2.resp_valid && t < 20) begin @(posedge clk); #1; t++; end
        check({nm, "_resp_seen"}, 32'(b2.resp_valid), 32'h1);
        check({nm, "_rdata"}, b2.resp_rdata, erd);
        check({nm, "_err"}, 32'(b2.resp_err), 32'(eerr));
        t = 0;
        while (!b2.req_ready && t < 20) begin @(posedge clk); #1; t++; end
        if (eerr) check({nm, "_no_write"}, 32'(ns_we - we0), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, t;
        logic [2:0] codes [5];
        logic [31:0] a;
        codes[0] = DM_WORD; codes[1] = DM_HALFWORD; codes[2] = DM_HALFWORD_UNSIGNED;
        codes[3] = DM_BYTE; codes[4] = DM_BYTE_UNSIGNED;
        b.req_valid = 1'b0; b.req_we = 1'b0; b.req_type = DM_WORD; b.req_addr = '0;
        b.req_wdata = '0; b.resp_ready = 1'b1;
        b2.req_valid = 1'b0; b2.req_we = 1'b0; b2.req_type = DM_WORD; b2.req_addr = '0;
        b2.req_wdata = '0; b2.resp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_req_ready", 32'(b.req_ready), 32'h1);
        check("rst_resp_valid", 32'(b.resp_valid), 32'h0);
        check("rst_resp_rdata", b.resp_rdata, 32'h0);
        check("rst_resp_err", 32'(b.resp_err), 32'h0);
        check("rst_mem_we", 32'(b.mem_we), 32'h0);
        check("rst_mem_addr", b.mem_addr, 32'h0);
        check("rst_mem_wdata", b.mem_wdata, 32'h0);

        // Reject-mode instance (memory pattern: word i = 0x80F0_000i).
        run_ns("ns_lh3", 1'b0, DM_HALFWORD, 32'h3, 32'h0, 32'h0, 1'b1);
        run_ns("ns_lw1", 1'b0, DM_WORD, 32'h1, 32'h0, 32'h0, 1'b1);
        run_ns("ns_lbu2", 1'b0, DM_BYTE_UNSIGNED, 32'h2, 32'h0, 32'h0000_00F0, 1'b0);
        run_ns("ns_lh2", 1'b0, DM_HALFWORD, 32'h2, 32'h0, 32'hFFFF_80F0, 1'b0);
        run_ns("ns_sb5", 1'b1, DM_BYTE, 32'h5, 32'h5A, 32'h0, 1'b0);
        run_ns("ns_sw6", 1'b1, DM_WORD, 32'h6, 32'h1234_5678, 32'h0, 1'b1);
        run_ns("ns_lw4", 1'b0, DM_WORD, 32'h4, 32'h0, 32'h80F0_5A01, 1'b0);
        check("ns_write_total", 32'(ns_we), 32'h1);

        for (int w = 0; w < 16; w++) poke(w, $urandom);

        poke(0, 32'h8899_AABB);
        run(1'b0, DM_BYTE, 32'h1, 32'h0, 0, lat);
        check("lb_lit", last_rdata, 32'hFFFF_FFAA);
        check("lb_lat", 32'(lat), 32'd2);
        run(1'b0, DM_BYTE_UNSIGNED, 32'h1, 32'h0, 0, lat);
        check("lbu_lit", last_rdata, 32'h0000_00AA);

        poke(1, 32'h1122_3344);
        run(1'b1, DM_HALFWORD, 32'h6, 32'h0000_BEEF, 0, lat);
        check("sh_lit", mem[1], 32'hBEEF_3344);
        check("sh_lat", 32'(lat), 32'd3);

        poke(0, 32'h4433_2211); poke(1, 32'h8877_6655);
        run(1'b0, DM_WORD, 32'h3, 32'h0, 0, lat);
        check("lw3_lit", last_rdata, 32'h7766_5544);
        check("lw3_lat", 32'(lat), 32'd3);

        poke(0, 32'h0); poke(1, 32'h0);
        run(1'b1, DM_WORD, 32'h2, 32'hDDCC_BBAA, 0, lat);
        check("sw2_lo_lit", mem[0], 32'hBBAA_0000);
        check("sw2_hi_lit", mem[1], 32'h0000_DDCC);
        check("sw2_lat", 32'(lat), 32'd5);

        poke(2, 32'hCAFE_F00D);
        run(1'b0, DM_HALFWORD_UNSIGNED, 32'h8, 32'h0, 4, lat);
        check("hold_lit", last_rdata, 32'h0000_F00D);

        // Reset while the first word of a crossing store is being written.
        poke(0, 32'h0); poke(1, 32'h0);
        b.req_valid = 1'b1; b.req_we = 1'b1; b.req_type = DM_WORD; b.req_addr = 32'h2;
        b.req_wdata = 32'hDDCC_BBAA; b.resp_ready = 1'b1;
        @(posedge clk); #1;
        b.req_valid = 1'b0;
        t = 0;
        while (!b.mem_we && t < 10) begin @(posedge clk); #1; t++; end
        check("rst_reach_wr0", 32'(b.mem_we), 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_req_ready", 32'(b.req_ready), 32'h1);
        check("midrst_mem_we", 32'(b.mem_we), 32'h0);
        check("midrst_resp_valid", 32'(b.resp_valid), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("midrst_wr0_kept", mem[0], 32'hBBAA_0000);
        check("midrst_no_wr1", mem[1], 32'h0);
        poke(0, $urandom); poke(1, $urandom);

        for (int k = 0; k < 200; k++) begin
            t = $urandom_range(0, 9);
            if (t == 0)      a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else if (t == 1) a = 32'd60 + 32'($urandom_range(0, 7));
            else             a = 32'($urandom_range(0, 63));
            run(1'($urandom_range(0, 1)), codes[$urandom_range(0, 4)], a, $urandom,
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
